// File: rtl/prediction_update_scheduler_pkg.sv
// Shared state encoding and default sizing
// for the predictor update scheduler.
package prediction_update_scheduler_pkg;

  localparam int unsigned DEF_IW   = 8;
  localparam int unsigned DEF_CW   = 2;
  localparam int unsigned DEF_QD   = 4;
  localparam int unsigned DEF_INIT = 0;

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } sched_state_e;

  function automatic int unsigned qcw(
    input int unsigned depth
  );
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/prediction_update_scheduler_if.sv
// Update, rollback, table-write and forwarding
// signals between predictor logic and scheduler.
interface prediction_update_scheduler_if
  import prediction_update_scheduler_pkg::*;
#(
  parameter int unsigned IW = DEF_IW,
  parameter int unsigned CW = DEF_CW,
  parameter int unsigned QD = DEF_QD
);

  localparam int unsigned QW = qcw(QD);

  logic          clear_req;
  logic          rb_valid;
  logic [IW-1:0] rb_index;
  logic [CW-1:0] rb_count;
  logic          up_valid;
  logic [IW-1:0] up_index;
  logic [CW-1:0] up_count;
  logic          up_ready;
  logic          tbl_wr_en;
  logic [IW-1:0] tbl_wr_index;
  logic [CW-1:0] tbl_wr_count;
  logic [IW-1:0] rd_index;
  logic [CW-1:0] rd_count_tbl;
  logic [CW-1:0] rd_count;
  logic          init_busy;
  logic [QW-1:0] q_count;

  modport master (
    output clear_req,
    output rb_valid, rb_index, rb_count,
    output up_valid, up_index, up_count,
    input  up_ready,
    input  tbl_wr_en, tbl_wr_index, tbl_wr_count,
    output rd_index, rd_count_tbl,
    input  rd_count,
    input  init_busy, q_count
  );

  modport slave (
    input  clear_req,
    input  rb_valid, rb_index, rb_count,
    input  up_valid, up_index, up_count,
    output up_ready,
    output tbl_wr_en, tbl_wr_index, tbl_wr_count,
    input  rd_index, rd_count_tbl,
    output rd_count,
    output init_busy, q_count
  );

endinterface

// File: rtl/prediction_update_scheduler_update_queue.sv
// Circular commit-update FIFO with per-entry valid
// bits, kill-by-index and youngest-match search.
module update_queue
  import prediction_update_scheduler_pkg::*;
#(
  parameter int unsigned IW = DEF_IW,
  parameter int unsigned CW = DEF_CW,
  parameter int unsigned QD = DEF_QD,
  localparam int unsigned PW = $clog2(QD),
  localparam int unsigned QW = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [IW-1:0] push_index_i,
  input  logic [CW-1:0] push_count_i,
  input  logic          pop_i,
  input  logic          kill_i,
  input  logic [IW-1:0] kill_index_i,
  output logic          empty_o,
  output logic          full_o,
  output logic [QW-1:0] count_o,
  output logic          head_valid_o,
  output logic [IW-1:0] head_index_o,
  output logic [CW-1:0] head_count_o,
  input  logic [IW-1:0] srch_index_i,
  output logic          srch_hit_o,
  output logic [CW-1:0] srch_count_o
);

  logic [IW-1:0] idx_q [QD];
  logic [CW-1:0] cnt_q [QD];
  logic [QD-1:0] vld_q, vld_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [QW-1:0] occ_q, occ_d;
  logic [PW-1:0] slot;
  logic          push_ok, pop_ok;

  assign empty_o      = (occ_q == '0);
  assign full_o       = (occ_q == QW'(QD));
  assign count_o      = occ_q;
  assign head_valid_o = vld_q[rd_q];
  assign head_index_o = idx_q[rd_q];
  assign head_count_o = cnt_q[rd_q];
  assign push_ok      = push_i && !full_o;
  assign pop_ok       = pop_i && !empty_o;

  // Kill before push so a same-cycle enqueue survives.
  always_comb begin
    vld_d = vld_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    if (kill_i) begin
      for (int i = 0; i < QD; i++) begin
        if (idx_q[i] == kill_index_i) begin
          vld_d[i] = 1'b0;
        end
      end
    end
    if (pop_ok) begin
      rd_d = rd_q + PW'(1);
    end
    if (push_ok) begin
      wr_d        = wr_q + PW'(1);
      vld_d[wr_q] = 1'b1;
    end
    occ_d = occ_q + QW'(push_ok) - QW'(pop_ok);
    if (flush_i) begin
      vld_d = '0;
      rd_d  = '0;
      wr_d  = '0;
      occ_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      occ_q <= '0;
    end else begin
      vld_q <= vld_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      occ_q <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      idx_q[wr_q] <= push_index_i;
      cnt_q[wr_q] <= push_count_i;
    end
  end

  // Walk oldest to youngest; the last hit wins.
  always_comb begin
    srch_hit_o   = 1'b0;
    srch_count_o = '0;
    slot         = '0;
    for (int i = 0; i < QD; i++) begin
      slot = rd_q + PW'(i);
      if (QW'(i) < occ_q && vld_q[slot] &&
          idx_q[slot] == srch_index_i) begin
        srch_hit_o   = 1'b1;
        srch_count_o = cnt_q[slot];
      end
    end
  end

endmodule

// File: rtl/prediction_update_scheduler.sv
// Sole writer of the pattern table: init sweep,
// rollback restores and queued commit updates.
module prediction_update_scheduler
  import prediction_update_scheduler_pkg::*;
#(
  parameter int unsigned INDEX_WIDTH   = DEF_IW,
  parameter int unsigned COUNTER_WIDTH = DEF_CW,
  parameter int unsigned QUEUE_DEPTH   = DEF_QD,
  parameter int unsigned INIT_COUNT    = DEF_INIT
) (
  input logic clk,
  input logic rst_n,
  prediction_update_scheduler_if.slave bus
);

  localparam int unsigned IW = INDEX_WIDTH;
  localparam int unsigned CW = COUNTER_WIDTH;
  localparam int unsigned QD = QUEUE_DEPTH;
  localparam int unsigned QW = qcw(QD);

  sched_state_e  state_q;
  logic [IW:0]   ptr_q;
  logic [IW:0]   ptr_inc;
  logic          run, init_wr;
  logic          rb_go, pop_go, push_go;
  logic          q_empty, q_full;
  logic [QW-1:0] q_cnt;
  logic          head_vld;
  logic [IW-1:0] head_idx;
  logic [CW-1:0] head_cnt;
  logic          srch_hit;
  logic [CW-1:0] srch_cnt;

  assign ptr_inc = ptr_q + (IW+1)'(1);
  assign run     = rst_n && (state_q == S_RUN);
  assign init_wr = rst_n && (state_q == S_INIT);
  assign rb_go   = run && !bus.clear_req && bus.rb_valid;
  assign pop_go  = run && !bus.clear_req &&
                   !bus.rb_valid && !q_empty;
  assign push_go = bus.up_valid && bus.up_ready;

  assign bus.up_ready  = run && !q_full;
  assign bus.init_busy = !rst_n || (state_q == S_INIT);
  assign bus.q_count   = rst_n ? q_cnt : '0;

  update_queue #(
    .IW (IW),
    .CW (CW),
    .QD (QD)
  ) u_queue (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (rst_n && bus.clear_req),
    .push_i       (push_go),
    .push_index_i (bus.up_index),
    .push_count_i (bus.up_count),
    .pop_i        (pop_go),
    .kill_i       (rb_go),
    .kill_index_i (bus.rb_index),
    .empty_o      (q_empty),
    .full_o       (q_full),
    .count_o      (q_cnt),
    .head_valid_o (head_vld),
    .head_index_o (head_idx),
    .head_count_o (head_cnt),
    .srch_index_i (bus.rd_index),
    .srch_hit_o   (srch_hit),
    .srch_count_o (srch_cnt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      ptr_q   <= '0;
    end else begin
      unique case (state_q)
        S_INIT: begin
          if (bus.clear_req) begin
            ptr_q <= '0;
          end else if (ptr_inc[IW]) begin
            state_q <= S_RUN;
            ptr_q   <= '0;
          end else begin
            ptr_q <= ptr_inc;
          end
        end
        S_RUN: begin
          if (bus.clear_req) begin
            state_q <= S_INIT;
            ptr_q   <= '0;
          end
        end
        default: begin
          state_q <= S_INIT;
          ptr_q   <= '0;
        end
      endcase
    end
  end

  // Killed heads pop silently with the strobe low.
  always_comb begin
    bus.tbl_wr_en    = 1'b0;
    bus.tbl_wr_index = '0;
    bus.tbl_wr_count = '0;
    unique case (1'b1)
      init_wr: begin
        bus.tbl_wr_en    = 1'b1;
        bus.tbl_wr_index = ptr_q[IW-1:0];
        bus.tbl_wr_count = CW'(INIT_COUNT);
      end
      rb_go: begin
        bus.tbl_wr_en    = 1'b1;
        bus.tbl_wr_index = bus.rb_index;
        bus.tbl_wr_count = bus.rb_count;
      end
      pop_go: begin
        bus.tbl_wr_en    = head_vld;
        bus.tbl_wr_index = head_idx;
        bus.tbl_wr_count = head_cnt;
      end
      default: ;
    endcase
  end

  always_comb begin
    if (!rst_n) begin
      bus.rd_count = bus.rd_count_tbl;
    end else if (state_q == S_INIT) begin
      bus.rd_count = CW'(INIT_COUNT);
    end else if (bus.rb_valid &&
                 bus.rb_index == bus.rd_index) begin
      bus.rd_count = bus.rb_count;
    end else if (srch_hit) begin
      bus.rd_count = srch_cnt;
    end else begin
      bus.rd_count = bus.rd_count_tbl;
    end
  end

endmodule
